// File: rtl/mfp_seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mfp_seg_pkg
// Purpose  : Shared constants for the 7-segment scan driver: digit count,
//            digit index width, special glyph codes and active-low segment
//            patterns ordered {a,b,c,d,e,f,g}.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mfp_seg_pkg;

  localparam int DIGIT_CNT = 8;
  localparam int IDX_W     = 3;

  // Glyph codes above the hex range
  localparam logic [4:0] GLYPH_BLANK = 5'h10;
  localparam logic [4:0] GLYPH_DASH  = 5'h11;
  localparam logic [4:0] GLYPH_H     = 5'h12;
  localparam logic [4:0] GLYPH_L     = 5'h13;
  localparam logic [4:0] GLYPH_P     = 5'h14;
  localparam logic [4:0] GLYPH_U     = 5'h15;
  localparam logic [4:0] GLYPH_R     = 5'h16;
  localparam logic [4:0] GLYPH_N     = 5'h17;

  // Active-low segment patterns, {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_H     = 7'b1001000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_N     = 7'b1101010;

endpackage
`default_nettype wire

// File: rtl/mfp_seg_glyph_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mfp_seg_glyph_decode
// Purpose  : Combinational glyph decoder, 5-bit glyph code to active-low
//            segment pattern {a,b,c,d,e,f,g}. Unassigned codes are blank.
// Ports    : i_code  [4:0] glyph code
//            o_seg_n [6:0] active-low segments
// Revision : 1.0 - initial release
// ============================================================================
module mfp_seg_glyph_decode
  import mfp_seg_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_code)
      5'h00:      o_seg_n = SEG_0;
      5'h01:      o_seg_n = SEG_1;
      5'h02:      o_seg_n = SEG_2;
      5'h03:      o_seg_n = SEG_3;
      5'h04:      o_seg_n = SEG_4;
      5'h05:      o_seg_n = SEG_5;
      5'h06:      o_seg_n = SEG_6;
      5'h07:      o_seg_n = SEG_7;
      5'h08:      o_seg_n = SEG_8;
      5'h09:      o_seg_n = SEG_9;
      5'h0A:      o_seg_n = SEG_A;
      5'h0B:      o_seg_n = SEG_B;
      5'h0C:      o_seg_n = SEG_C;
      5'h0D:      o_seg_n = SEG_D;
      5'h0E:      o_seg_n = SEG_E;
      5'h0F:      o_seg_n = SEG_F;
      GLYPH_DASH: o_seg_n = SEG_DASH;
      GLYPH_H:    o_seg_n = SEG_H;
      GLYPH_L:    o_seg_n = SEG_L;
      GLYPH_P:    o_seg_n = SEG_P;
      GLYPH_U:    o_seg_n = SEG_U;
      GLYPH_R:    o_seg_n = SEG_R;
      GLYPH_N:    o_seg_n = SEG_N;
      default:    o_seg_n = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mfp_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mfp_seg_scan_driver
// Purpose  : Time-multiplexed 8-digit 7-segment scan driver with per-frame
//            input snapshot, anti-ghosting blank interval at the start of
//            each digit slot, and glyph decode.
//            Build option: MFP_SEG_BRIGHT_EN adds a 4-bit PWM brightness
//            control (BRIGHT port) within the non-blank part of each slot.
// Ports    : HCLK       in   system clock
//            HRESETn    in   asynchronous active-low reset
//            EN[7:0]    in   digit enables
//            DIGITS[63:0] in glyph codes, byte i for digit i
//            DP[7:0]    in   decimal points
//            BRIGHT[3:0] in  brightness (MFP_SEG_BRIGHT_EN only)
//            DISPENOUT[7:0] out anodes, active-low
//            DISPOUT[7:0]   out cathodes, active-low, {dp,a,b,c,d,e,f,g}
// Revision : 1.0 - initial release
// ============================================================================
module mfp_seg_scan_driver
  import mfp_seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
)
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  EN,
  input  logic [63:0] DIGITS,
  input  logic [7:0]  DP,
`ifdef MFP_SEG_BRIGHT_EN
  input  logic [3:0]  BRIGHT,
`endif
  output logic [7:0]  DISPENOUT,
  output logic [7:0]  DISPOUT
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]     r_slot_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_en_snap;
  logic [63:0]          r_digits_snap;
  logic [7:0]           r_dp_snap;

  logic                 w_slot_last;
  logic                 w_frame_start;
  logic                 w_past_blank;
  logic                 w_pwm_on;
  logic                 w_active;
  logic [4:0]           w_code;
  logic [6:0]           w_seg_n;
  logic [DIGIT_CNT-1:0] w_onehot;

  assign w_slot_last   = (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_frame_start = (r_idx == '0) && (r_slot_cnt == '0);
  assign w_past_blank  = (r_slot_cnt >= CNT_W'(BLANK_CYC));

  // Slot counter and digit index
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (w_slot_last) begin
      r_slot_cnt <= '0;
      r_idx      <= r_idx + IDX_W'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + CNT_W'(1);
    end
  end

  // Frame snapshot: inputs are frozen for a full 8-slot frame so a register
  // update in the middle of a scan never produces a mixed display.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_en_snap     <= '0;
      r_digits_snap <= '0;
      r_dp_snap     <= '0;
    end else if (w_frame_start) begin
      r_en_snap     <= EN;
      r_digits_snap <= DIGITS;
      r_dp_snap     <= DP;
    end
  end

`ifdef MFP_SEG_BRIGHT_EN
  logic [3:0] r_pwm_cnt;
  logic [3:0] r_bright_snap;

  // PWM phase holds at 0 through the blank window, then free-runs mod 16.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pwm_cnt     <= '0;
      r_bright_snap <= '0;
    end else begin
      if (w_slot_last) begin
        r_pwm_cnt <= '0;
      end else if (w_past_blank) begin
        r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
      if (w_frame_start) begin
        r_bright_snap <= BRIGHT;
      end
    end
  end

  assign w_pwm_on = (r_pwm_cnt <= r_bright_snap);
`else
  assign w_pwm_on = 1'b1;
`endif

  assign w_code   = r_digits_snap[{r_idx, 3'b000} +: 5];
  assign w_active = r_en_snap[r_idx] & w_past_blank & w_pwm_on;
  assign w_onehot = {{(DIGIT_CNT-1){1'b0}}, 1'b1} << r_idx;

  mfp_seg_glyph_decode u_glyph_decode (
    .i_code  (w_code),
    .o_seg_n (w_seg_n)
  );

  // Registered pin drivers; reset blanks the display immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      DISPENOUT <= 8'hFF;
      DISPOUT   <= 8'hFF;
    end else begin
      DISPENOUT <= ~(w_onehot & {DIGIT_CNT{w_active}});
      DISPOUT   <= w_active ? {~r_dp_snap[r_idx], w_seg_n} : 8'hFF;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfp_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mfp_seg_scan_driver
// Purpose  : Self-checking bench for mfp_seg_scan_driver with SCAN_DIV=8,
//            BLANK_CYC=2 (64-cycle frame). Directed input sequences with
//            hand-computed spot values plus a per-cycle expectation built
//            from a hand-written glyph table and the frame timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = SD * 8;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [7:0]  EN;
  logic [63:0] DIGITS;
  logic [7:0]  DP;
  logic [7:0]  DISPENOUT;
  logic [7:0]  DISPOUT;
`ifdef MFP_SEG_BRIGHT_EN
  logic [3:0]  BRIGHT = 4'hF;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;  // clock edges since reset release

  // Frame snapshot as the bench expects the design to hold it
  logic [7:0]  m_en;
  logic [7:0]  m_dp;
  logic [63:0] m_digits;

  always #5 HCLK = ~HCLK;

  mfp_seg_scan_driver #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .EN        (EN),
    .DIGITS    (DIGITS),
    .DP        (DP),
`ifdef MFP_SEG_BRIGHT_EN
    .BRIGHT    (BRIGHT),
`endif
    .DISPENOUT (DISPENOUT),
    .DISPOUT   (DISPOUT)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cyc %0d): got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'h00: s = 7'b0000001;
      5'h01: s = 7'b1001111;
      5'h02: s = 7'b0010010;
      5'h03: s = 7'b0000110;
      5'h04: s = 7'b1001100;
      5'h05: s = 7'b0100100;
      5'h06: s = 7'b0100000;
      5'h07: s = 7'b0001111;
      5'h08: s = 7'b0000000;
      5'h09: s = 7'b0000100;
      5'h0A: s = 7'b0001000;
      5'h0B: s = 7'b1100000;
      5'h0C: s = 7'b0110001;
      5'h0D: s = 7'b1000010;
      5'h0E: s = 7'b0110000;
      5'h0F: s = 7'b0111000;
      5'h11: s = 7'b1111110;
      5'h12: s = 7'b1001000;
      5'h13: s = 7'b1110001;
      5'h14: s = 7'b0011000;
      5'h15: s = 7'b1000001;
      5'h16: s = 7'b1111010;
      5'h17: s = 7'b1101010;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One clock: the output after this edge reflects counter state m = cyc,
  // using the snapshot held before this edge.
  task automatic step();
    int         m;
    int         slot;
    int         pos;
    logic       act;
    logic [7:0] b;
    logic [7:0] e_an;
    logic [7:0] e_cat;
    @(posedge HCLK);
    m     = cyc;
    slot  = (m / SD) % 8;
    pos   = m % SD;
    act   = m_en[slot] && (pos >= BC);
    b     = m_digits[slot*8 +: 8];
    e_an  = act ? ~(8'd1 << slot) : 8'hFF;
    e_cat = act ? {~m_dp[slot], ref_seg(b[4:0])} : 8'hFF;
    if ((m % FRAME) == 0) begin
      m_en     = EN;
      m_dp     = DP;
      m_digits = DIGITS;
    end
    cyc++;
    #1;
    check("anode", {24'd0, DISPENOUT}, {24'd0, e_an});
    check("cathode", {24'd0, DISPOUT}, {24'd0, e_cat});
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    EN       = 8'hFF;
    DIGITS   = 64'h0706050403020100;
    DP       = 8'h00;
    m_en     = 8'h00;
    m_dp     = 8'h00;
    m_digits = 64'h0;

    // Reset hold
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_anode", {24'd0, DISPENOUT}, 32'hFF);
    check("rst_cathode", {24'd0, DISPOUT}, 32'hFF);

    @(negedge HCLK);
    HRESETn = 1'b1;

    // First slot: two blank cycles then digit 0 shows '0'
    run_to(2);
    check("hand_blank_an", {24'd0, DISPENOUT}, 32'hFF);
    run_to(3);
    check("hand_d0_an", {24'd0, DISPENOUT}, 32'hFE);
    check("hand_d0_cat", {24'd0, DISPOUT}, 32'h81);
    run_to(11);
    check("hand_d1_an", {24'd0, DISPENOUT}, 32'hFD);
    check("hand_d1_cat", {24'd0, DISPOUT}, 32'hCF);
    run_to(59);
    check("hand_d7_an", {24'd0, DISPENOUT}, 32'h7F);
    check("hand_d7_cat", {24'd0, DISPOUT}, 32'h8F);
    run_to(67);
    check("hand_wrap_an", {24'd0, DISPENOUT}, 32'hFE);

    // Disabled digit 2 from the frame at 192
    run_to(140);
    EN = 8'hFB;
    run_to(211);
    check("hand_dis_an", {24'd0, DISPENOUT}, 32'hFF);
    check("hand_dis_cat", {24'd0, DISPOUT}, 32'hFF);
    run_to(219);
    check("hand_dis_next", {24'd0, DISPENOUT}, 32'hF7);
    run_to(260);
    EN = 8'hFF;

    // Tearing: byte 5 changes in slot 3 of the frame at 320
    run_to(348);
    DIGITS = 64'h0706080403020100;
    run_to(363);
    check("hand_tear_an", {24'd0, DISPENOUT}, 32'hDF);
    check("hand_tear_old", {24'd0, DISPOUT}, 32'b10100100);
    run_to(427);
    check("hand_tear_new", {24'd0, DISPOUT}, 32'b10000000);

    // Blank with DP, all-off code, upper bits ignored, special letters
    run_to(400);
    DIGITS = {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'hE3, 8'h1F, 8'h10};
    DP     = 8'h81;
    run_to(451);
    check("hand_dp_an", {24'd0, DISPENOUT}, 32'hFE);
    check("hand_dp_cat", {24'd0, DISPOUT}, 32'b01111111);
    run_to(459);
    check("hand_1f_cat", {24'd0, DISPOUT}, 32'hFF);
    run_to(467);
    check("hand_hi_bits", {24'd0, DISPOUT}, 32'b10000110);
    run_to(520);
    DIGITS = {8'h17, 8'h16, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    DP     = 8'h00;
    run_to(650);
    DIGITS = {8'h09, 8'h18, 8'hFF, 8'h0C, 8'hA5, 8'h42, 8'h71, 8'h80};
    DP     = 8'hAA;
    run_to(715);
    check("hand_dash_cat", {24'd0, DISPOUT}, 32'b01111110);

    // Asynchronous reset in the middle of slot 4 of the frame at 768
    run_to(804);
    check("hand_pre_rst", {24'd0, DISPENOUT}, 32'hEF);
    #2;
    HRESETn = 1'b0;
    #1;
    check("arst_anode", {24'd0, DISPENOUT}, 32'hFF);
    check("arst_cathode", {24'd0, DISPOUT}, 32'hFF);
    repeat (2) @(posedge HCLK);
    #1;
    check("arst_hold", {24'd0, DISPENOUT}, 32'hFF);
    EN       = 8'hFF;
    DIGITS   = 64'h0706050403020100;
    DP       = 8'h00;
    m_en     = 8'h00;
    m_dp     = 8'h00;
    m_digits = 64'h0;
    cyc      = 0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    run_to(3);
    check("restart_an", {24'd0, DISPENOUT}, 32'hFE);
    check("restart_cat", {24'd0, DISPOUT}, 32'h81);
    run_to(70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
